// File: rtl/prga_if.sv
// PRGA bus: start/ready handshake, S/ct/pt memory ports, debug count.
// slave = prga core side, master = environment (memories, requester).
interface prga_if;
  logic        en;
  logic        rdy;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_rddata;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;
  logic [15:0] dbg_cycles;

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren,
    output ct_addr, pt_addr, pt_wrdata, pt_wren,
    output dbg_cycles
  );

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren,
    input  ct_addr, pt_addr, pt_wrdata, pt_wren,
    input  dbg_cycles
  );
endinterface

// File: rtl/prga.sv
// ARC4 PRGA decryptor of a length-prefixed message (ct -> pt) over a
// preloaded S array. Ports: clk, rst (sync, high), bus (prga_if.slave).
// Define PRGA_CYCLE_COUNT_EN to enable the dbg_cycles busy counter.
module prga (
  input  logic clk,
  input  logic rst,
  prga_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WAIT, SI_RD, SI_WAIT, SJ_RD,
    SJ_WAIT, SWAP_I, SWAP_J, PAD_RD, PAD_WAIT, PT_WR
  } state_t;

  state_t st, nxt;

  logic [7:0] i, j, k, len, si, sj, ctb, pad;

  logic       rdy;
  logic [7:0] s_addr, s_wrdata, ct_addr;
  logic [7:0] pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt       = st;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    unique case (st)
      IDLE: begin
        rdy = 1'b1;
        if (bus.en) nxt = LEN_RD;
      end
      LEN_RD: begin
        ct_addr = 8'd0;
        nxt     = LEN_WAIT;
      end
      LEN_WAIT: begin
        pt_addr   = 8'd0;
        pt_wrdata = bus.ct_rddata;
        pt_wren   = 1'b1;
        nxt = (bus.ct_rddata == 8'd0) ? IDLE : SI_RD;
      end
      SI_RD: begin
        s_addr  = i + 8'd1;
        ct_addr = k;
        nxt     = SI_WAIT;
      end
      SI_WAIT: nxt = SJ_RD;
      SJ_RD: begin
        s_addr = j + si;
        nxt    = SJ_WAIT;
      end
      SJ_WAIT: nxt = SWAP_I;
      SWAP_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
        nxt      = SWAP_J;
      end
      SWAP_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        nxt      = PAD_RD;
      end
      PAD_RD: begin
        s_addr = si + sj;
        nxt    = PAD_WAIT;
      end
      PAD_WAIT: nxt = PT_WR;
      PT_WR: begin
        pt_addr   = k;
        pt_wrdata = pad ^ ctb;
        pt_wren   = 1'b1;
        nxt = (k == len) ? IDLE : SI_RD;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= 8'd0;
      j   <= 8'd0;
      k   <= 8'd0;
      len <= 8'd0;
      si  <= 8'd0;
      sj  <= 8'd0;
      ctb <= 8'd0;
      pad <= 8'd0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.en) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= 8'd1;
          end
        end
        LEN_WAIT: len <= bus.ct_rddata;
        SI_RD:    i   <= i + 8'd1;
        SI_WAIT: begin
          si  <= bus.s_rddata;
          ctb <= bus.ct_rddata;
        end
        SJ_RD:    j   <= j + si;
        SJ_WAIT:  sj  <= bus.s_rddata;
        PAD_WAIT: pad <= bus.s_rddata;
        // k stops at len, so a 255-byte message never wraps k to 0
        PT_WR:    if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

`ifdef PRGA_CYCLE_COUNT_EN
  // The accept cycle counts as busy, so a run reads 3+9L at rdy.
  logic [15:0] cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= 16'd0;
    end else if (st == IDLE) begin
      if (bus.en) cyc <= 16'd1;
    end else if (cyc != 16'hFFFF) begin
      cyc <= cyc + 16'd1;
    end
  end

  assign bus.dbg_cycles = cyc;
`else
  assign bus.dbg_cycles = 16'd0;
`endif

  assign bus.rdy       = rdy;
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.ct_addr   = ct_addr;
  assign bus.pt_addr   = pt_addr;
  assign bus.pt_wrdata = pt_wrdata;
  assign bus.pt_wren   = pt_wren;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: synchronous memory models, pt-write scoreboard,
// directed runs (identity S, KSA "Key", mid-run reset, L=255).
module tb_prga;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prga_if bus ();

  prga dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [256];
  logic       load_s = 1'b0;
  int         s_wr_cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];

  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (bus.s_wren) begin
      s_mem[bus.s_addr] <= bus.s_wrdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
  end

  // pt write monitor / scoreboard
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.pt_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pt_extra got addr %0d data %02h required none",
                 bus.pt_addr, bus.pt_wrdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.pt_addr, bus.pt_wrdata} !== e) begin
          errors++;
          $display("FAIL pt_write got %0d:%02h required %0d:%02h",
                   bus.pt_addr, bus.pt_wrdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({a[7:0], d[7:0]});
  endtask

  task automatic s_identity();
    for (int x = 0; x < 256; x++) s_init[x] = x[7:0];
  endtask

  task automatic s_ksa();
    logic [7:0] key [3];
    logic [7:0] jj, t;
    key[0] = 8'h4B;
    key[1] = 8'h65;
    key[2] = 8'h79;
    s_identity();
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + s_init[x] + key[x % 3];
      t = s_init[x];
      s_init[x] = s_init[jj];
      s_init[jj] = t;
    end
  endtask

  task automatic load();
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  // Reference RC4 keystream over s_init, xored with ct_mem.
  task automatic push_rc4(input int len);
    logic [7:0] s [256];
    logic [7:0] ii, jj, t;
    s = s_init;
    ii = 8'd0;
    jj = 8'd0;
    push(0, len);
    for (int n = 1; n <= len; n++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii];
      s[ii] = s[jj];
      s[jj] = t;
      t = s[ii] + s[jj];
      push(n, s[t] ^ ct_mem[n]);
    end
  endtask

  task automatic run(input string nm, input int len,
                     input bit pulse);
    int c;
    int w0;
    w0 = s_wr_cnt;
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    c = 1;
    while (c < 4000) begin
      @(negedge clk);
      if (bus.rdy) break;
      if (pulse) bus.en = (c < 10) ? c[0] : 1'b0;
      @(posedge clk);
      c++;
    end
    bus.en = 1'b0;
    if (c >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d required %0d",
               nm, c, 3 + 9 * len);
    end
    chk({nm, "_cycles"}, c, 3 + 9 * len);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
    if (len <= 2)
      chk({nm, "_s_writes"}, s_wr_cnt - w0, 2 * len);
`ifdef PRGA_CYCLE_COUNT_EN
    chk({nm, "_dbg"}, bus.dbg_cycles, 3 + 9 * len);
`else
    chk({nm, "_dbg"}, bus.dbg_cycles, 0);
`endif
  endtask

  initial begin
    logic [7:0] kct [10];
    logic [7:0] kpt [9];
    int bad;
    kct = '{8'd9, 8'hBB, 8'hF3, 8'h16, 8'hE8,
            8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    kpt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E,
            8'h74, 8'h65, 8'h78, 8'h74};
    rst    = 1'b1;
    bus.en = 1'b0;
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'd0;
    s_identity();
    load();
    @(negedge clk);
    chk("rst_rdy", bus.rdy, 1);
    chk("rst_wren", {bus.s_wren, bus.pt_wren}, 0);
    chk("rst_addr", {bus.s_addr, bus.ct_addr, bus.pt_addr}, 0);
    chk("rst_dbg", bus.dbg_cycles, 0);
    rst = 1'b0;

    // L=0
    ct_mem[0] = 8'd0;
    push(0, 0);
    run("len0", 0, 1'b0);

    // L=1, identity: i=j=1 swap, pad=s[2]
    ct_mem[0] = 8'd1;
    ct_mem[1] = 8'd0;
    push(0, 1);
    push(1, 8'h02);
    run("len1", 1, 1'b0);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (s_mem[x] != x[7:0]) bad++;
    chk("len1_s_same", bad, 0);

    // L=2, identity
    load();
    ct_mem[0] = 8'd2;
    ct_mem[2] = 8'd0;
    push(0, 2);
    push(1, 8'h02);
    push(2, 8'h05);
    run("len2", 2, 1'b0);
    chk("len2_s2", s_mem[2], 3);
    chk("len2_s3", s_mem[3], 2);

    // KSA key "Key" -> "Plaintext"
    s_ksa();
    load();
    for (int x = 0; x < 10; x++) ct_mem[x] = kct[x];
    push(0, 9);
    for (int x = 0; x < 9; x++) push(x + 1, kpt[x]);
    run("key", 9, 1'b0);

    // reset during SWAP_J of byte 1
    s_identity();
    load();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'd0;
    ct_mem[0] = 8'd1;
    push(0, 1);
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("swapj_wren", {bus.s_wren, bus.s_addr}, 9'h101);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rdy", bus.rdy, 1);
    chk("mid_rst_wren", {bus.s_wren, bus.pt_wren}, 0);
    chk("mid_rst_dbg", bus.dbg_cycles, 0);
    chk("mid_rst_q", exp_q.size(), 0);
    rst = 1'b0;
    load();
    push(0, 1);
    push(1, 8'h02);
    run("rerun", 1, 1'b1);

    // L=255 boundary: k stops at 255
    s_ksa();
    load();
    for (int x = 1; x < 256; x++) ct_mem[x] = x[7:0] ^ 8'h5A;
    ct_mem[0] = 8'd255;
    push_rc4(255);
    run("len255", 255, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
